// File: rtl/cpu_bus_pkg.sv
// Shared types and widths for the 6502 bus synchroniser.
package cpu_bus_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TRACE_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_READ,
    ST_WRITE_WAIT,
    ST_WRITE,
    ST_WAIT_FALL
  } bus_state_e;

endpackage

// File: rtl/cpu_bus_sync_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/cpu_bus_sync.sv
// 6502 bus to internal clock bridge: phi2 edge detect, RAM strobes, phi2 watchdog.
// Optional trace FIFO of completed cycles built when BUS_TRACE_EN is defined.
//
// state       | meaning
// ST_IDLE     | waiting for a phi2 rise
// ST_SETTLE   | letting address/rwbar settle before latching
// ST_READ     | ram_cs held until phi2 falls
// ST_WRITE_WAIT | tracking write data until phi2 falls
// ST_WRITE    | single-clock write strobe
// ST_WAIT_FALL| unselected or halted cycle, waiting for phi2 fall
module cpu_bus_sync
  import cpu_bus_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 4096
`ifdef BUS_TRACE_EN
  ,
  parameter int TRACE_DEPTH    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phi2,
  input  logic              rwbar,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sel,
  input  logic              halt,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              cycle_active,
  output logic              phi2_lost,
`ifdef BUS_TRACE_EN
  input  logic               trace_rd,
  output logic [TRACE_W-1:0] trace_data,
  output logic               trace_empty,
`endif
  output logic [15:0]       cycle_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic phi2_s2, phi2_s3_q, rw_s;
  logic phi2_rise, phi2_fall;
  logic [ADDR_W-1:0] addr_s1_q, addr_s2_q;
  logic [DATA_W-1:0] data_s1_q, data_s2_q;

  bus_state_e        state_q, state_d;
  logic [3:0]        settle_cnt_q, settle_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_datain_q, ram_datain_d;
  logic              ram_cs_q, ram_cs_d, ram_we_q, ram_we_d;
  logic              cycle_active_q, cycle_active_d;
  logic              phi2_lost_q, phi2_lost_d;
  logic [15:0]       cycle_count_q, cycle_count_d;
  logic              cycle_done;

  sync2 u_sync_phi2 (.clk(clk), .rst_n(reset), .d(phi2),  .q(phi2_s2));
  sync2 u_sync_rw   (.clk(clk), .rst_n(reset), .d(rwbar), .q(rw_s));

  assign phi2_rise = phi2_s2 & ~phi2_s3_q;
  assign phi2_fall = ~phi2_s2 & phi2_s3_q;

  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    ram_address_d  = ram_address_q;
    ram_datain_d   = ram_datain_q;
    ram_cs_d       = ram_cs_q;
    ram_we_d       = 1'b0;
    cycle_active_d = cycle_active_q;
    cycle_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (phi2_rise) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (phi2_fall) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          ram_address_d = addr_s2_q;
          if (!sel || halt) begin
            state_d = ST_WAIT_FALL;
          end else begin
            cycle_active_d = 1'b1;
            if (rw_s) begin
              state_d  = ST_READ;
              ram_cs_d = 1'b1;
            end else begin
              state_d      = ST_WRITE_WAIT;
              ram_datain_d = data_s2_q;
            end
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_READ: begin
        if (phi2_fall) begin
          ram_cs_d       = 1'b0;
          cycle_active_d = 1'b0;
          cycle_done     = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      ST_WRITE_WAIT: begin
        // on the fall clock the held value is the last sample taken with phi2 high
        if (phi2_fall) begin
          state_d  = ST_WRITE;
          ram_cs_d = 1'b1;
          ram_we_d = 1'b1;
        end else begin
          ram_datain_d = data_s2_q;
        end
      end
      ST_WRITE: begin
        ram_cs_d       = 1'b0;
        cycle_active_d = 1'b0;
        cycle_done     = 1'b1;
        if (phi2_rise) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_FALL: begin
        if (phi2_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wd_cnt_d    = wd_cnt_q;
    phi2_lost_d = phi2_lost_q;
    if (phi2_rise) begin
      wd_cnt_d    = '0;
      phi2_lost_d = 1'b0;
    end else if (wd_cnt_q != WD_LIMIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_d == WD_LIMIT) phi2_lost_d = 1'b1;
    end
    cycle_count_d = cycle_count_q + {15'd0, cycle_done};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phi2_s3_q      <= 1'b0;
      addr_s1_q      <= '0;
      addr_s2_q      <= '0;
      data_s1_q      <= '0;
      data_s2_q      <= '0;
      state_q        <= ST_IDLE;
      settle_cnt_q   <= '0;
      wd_cnt_q       <= '0;
      ram_address_q  <= '0;
      ram_datain_q   <= '0;
      ram_cs_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      cycle_active_q <= 1'b0;
      phi2_lost_q    <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      phi2_s3_q      <= phi2_s2;
      addr_s1_q      <= address;
      addr_s2_q      <= addr_s1_q;
      data_s1_q      <= data_in;
      data_s2_q      <= data_s1_q;
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      ram_address_q  <= ram_address_d;
      ram_datain_q   <= ram_datain_d;
      ram_cs_q       <= ram_cs_d;
      ram_we_q       <= ram_we_d;
      cycle_active_q <= cycle_active_d;
      phi2_lost_q    <= phi2_lost_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign ram_address  = ram_address_q;
  assign ram_datain   = ram_datain_q;
  assign ram_cs       = ram_cs_q;
  assign ram_we       = ram_we_q;
  assign cycle_active = cycle_active_q;
  assign phi2_lost    = phi2_lost_q;
  assign cycle_count  = cycle_count_q;

`ifdef BUS_TRACE_EN
  localparam int TP_W = $clog2(TRACE_DEPTH);

  logic [TRACE_W-1:0] trace_mem_q [TRACE_DEPTH];
  logic [TP_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TP_W:0]      tr_cnt_q, tr_cnt_d;
  logic [TRACE_W-1:0] push_data;
  logic               tr_full, tr_pop;

  assign tr_full   = tr_cnt_q[TP_W];
  assign tr_pop    = trace_rd && (tr_cnt_q != '0);
  assign push_data = (state_q == ST_READ) ? {1'b1, ram_address_q, data_s2_q}
                                          : {1'b0, ram_address_q, ram_datain_q};

  // a push into a full FIFO drops the oldest entry by advancing the read pointer
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tr_cnt_d = tr_cnt_q;
    if (cycle_done) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (tr_pop || tr_full) rd_ptr_d = rd_ptr_q + 1'b1;
      else                   tr_cnt_d = tr_cnt_q + 1'b1;
    end else if (tr_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      tr_cnt_d = tr_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tr_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tr_cnt_q <= tr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cycle_done) trace_mem_q[wr_ptr_q] <= push_data;
  end

  assign trace_empty = (tr_cnt_q == '0);
  assign trace_data  = trace_empty ? '0 : trace_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_cpu_bus_sync.sv
// Directed bench for cpu_bus_sync: read/write strobes, suppression, runt, watchdog, reset, trace.
module tb_cpu_bus_sync;

  logic        clk = 1'b0;
  logic        reset, phi2, rwbar, sel, halt;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [15:0] ram_address, cycle_count;
  logic [7:0]  ram_datain;
  logic        ram_cs, ram_we, cycle_active, phi2_lost;
`ifdef BUS_TRACE_EN
  logic        trace_rd;
  logic [24:0] trace_data;
  logic        trace_empty;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cpu_bus_sync dut (
    .clk(clk), .reset(reset), .phi2(phi2), .rwbar(rwbar), .address(address),
    .data_in(data_in), .sel(sel), .halt(halt), .ram_address(ram_address),
    .ram_datain(ram_datain), .ram_cs(ram_cs), .ram_we(ram_we),
    .cycle_active(cycle_active), .phi2_lost(phi2_lost),
`ifdef BUS_TRACE_EN
    .trace_rd(trace_rd), .trace_data(trace_data), .trace_empty(trace_empty),
`endif
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // one phi2 cycle, sampled on falling clk edges; i counts rising edges since the pin rose
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d0,
                           input logic [7:0] d1, input logic s, input logic h,
                           input logic hmid, input int high,
                           output int cs_cnt, output int we_cnt, output int first_cs,
                           output logic [7:0] wdat, output logic [15:0] caddr,
                           output logic act_mid);
    cs_cnt = 0; we_cnt = 0; first_cs = 0; wdat = 8'h00; caddr = 16'h0000; act_mid = 1'b0;
    @(negedge clk);
    address = a; rwbar = rw; data_in = d0; sel = s; halt = h; phi2 = 1'b1;
    for (int i = 1; i <= high + 8; i++) begin
      @(negedge clk);
      if (ram_cs) begin
        cs_cnt++;
        if (first_cs == 0) begin
          first_cs = i;
          caddr    = ram_address;
        end
      end
      if (ram_we) begin
        we_cnt++;
        wdat = ram_datain;
      end
      if (i == high / 2) begin
        act_mid = cycle_active;
        data_in = d1;
        if (hmid) halt = 1'b1;
      end
      if (i == high) phi2 = 1'b0;
    end
    halt = 1'b0;
    sel  = 1'b0;
  endtask

  int cs_n, we_n, first;
  logic [7:0]  wd;
  logic [15:0] ca;
  logic        am;

  initial begin
    reset = 1'b0; phi2 = 1'b0; rwbar = 1'b1; sel = 1'b0; halt = 1'b0;
    address = 16'h0000; data_in = 8'h00;
`ifdef BUS_TRACE_EN
    trace_rd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_cs", {31'd0, ram_cs}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_addr", {16'd0, ram_address}, 32'd0);
    check("rst_data", {24'd0, ram_datain}, 32'd0);
    check("rst_active", {31'd0, cycle_active}, 32'd0);
    check("rst_lost", {31'd0, phi2_lost}, 32'd0);
    check("rst_count", {16'd0, cycle_count}, 32'd0);

    bus_cycle(16'hFFFC, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 24, cs_n, we_n, first, wd, ca, am);
    check("rd_first_cs", first, 6);
    check("rd_cs_len", cs_n, 21);
    check("rd_we", we_n, 0);
    check("rd_addr", {16'd0, ca}, 32'h0000_FFFC);
    check("rd_active_mid", {31'd0, am}, 32'd1);
    check("rd_active_end", {31'd0, cycle_active}, 32'd0);
    check("rd_count", {16'd0, cycle_count}, 32'd1);

    bus_cycle(16'h8000, 1'b0, 8'h11, 8'hA5, 1'b1, 1'b0, 1'b0, 24, cs_n, we_n, first, wd, ca, am);
    check("wr_we_len", we_n, 1);
    check("wr_cs_len", cs_n, 1);
    check("wr_first_cs", first, 27);
    check("wr_data", {24'd0, wd}, 32'h0000_00A5);
    check("wr_addr", {16'd0, ca}, 32'h0000_8000);
    check("wr_count", {16'd0, cycle_count}, 32'd2);

    bus_cycle(16'h1234, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 24, cs_n, we_n, first, wd, ca, am);
    check("nosel_cs", cs_n, 0);
    check("nosel_we", we_n, 0);
    check("nosel_active", {31'd0, am}, 32'd0);
    check("nosel_count", {16'd0, cycle_count}, 32'd2);

    bus_cycle(16'h2000, 1'b0, 8'h33, 8'h44, 1'b1, 1'b1, 1'b0, 24, cs_n, we_n, first, wd, ca, am);
    check("halt_cs", cs_n, 0);
    check("halt_we", we_n, 0);
    check("halt_count", {16'd0, cycle_count}, 32'd2);

    bus_cycle(16'h0200, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 24, cs_n, we_n, first, wd, ca, am);
    check("hmid_cs_len", cs_n, 21);
    check("hmid_count", {16'd0, cycle_count}, 32'd3);

    bus_cycle(16'h0300, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2, cs_n, we_n, first, wd, ca, am);
    check("runt_cs", cs_n, 0);
    check("runt_we", we_n, 0);
    check("runt_count", {16'd0, cycle_count}, 32'd3);

    bus_cycle(16'h4321, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10, cs_n, we_n, first, wd, ca, am);
    check("post_runt_first", first, 6);
    check("post_runt_cs_len", cs_n, 7);
    check("post_runt_addr", {16'd0, ca}, 32'h0000_4321);
    check("post_runt_count", {16'd0, cycle_count}, 32'd4);

    repeat (3000) @(negedge clk);
    check("wd_not_yet", {31'd0, phi2_lost}, 32'd0);
    repeat (1200) @(negedge clk);
    check("wd_lost", {31'd0, phi2_lost}, 32'd1);
    phi2 = 1'b1;
    @(negedge clk);
    check("wd_still_lost", {31'd0, phi2_lost}, 32'd1);
    repeat (2) @(negedge clk);
    check("wd_cleared", {31'd0, phi2_lost}, 32'd0);
    phi2 = 1'b0;
    repeat (8) @(negedge clk);
    check("wd_nosel_count", {16'd0, cycle_count}, 32'd4);

    address = 16'h5555; rwbar = 1'b1; sel = 1'b1; phi2 = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_cs_before", {31'd0, ram_cs}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_cs", {31'd0, ram_cs}, 32'd0);
    check("mid_rst_active", {31'd0, cycle_active}, 32'd0);
    check("mid_rst_count", {16'd0, cycle_count}, 32'd0);
    check("mid_rst_addr", {16'd0, ram_address}, 32'd0);
    phi2 = 1'b0; sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("after_rst_cs", {31'd0, ram_cs}, 32'd0);
    check("after_rst_count", {16'd0, cycle_count}, 32'd0);

    for (int k = 1; k <= 20; k++) begin
      bus_cycle(16'h1000 + 16'(k), 1'b0, 8'(k), 8'(k), 1'b1, 1'b0, 1'b0, 12,
                cs_n, we_n, first, wd, ca, am);
    end
    check("burst_count", {16'd0, cycle_count}, 32'd20);
    check("burst_last_data", {24'd0, wd}, 32'd20);

`ifdef BUS_TRACE_EN
    check("tr_not_empty", {31'd0, trace_empty}, 32'd0);
    for (int k = 5; k <= 20; k++) begin
      check($sformatf("tr_entry_%0d", k), {7'd0, trace_data},
            {7'd0, 1'b0, 16'h1000 + 16'(k), 8'(k)});
      trace_rd = 1'b1;
      @(negedge clk);
      trace_rd = 1'b0;
    end
    check("tr_empty", {31'd0, trace_empty}, 32'd1);
    trace_rd = 1'b1;
    @(negedge clk);
    trace_rd = 1'b0;
    check("tr_pop_empty", {31'd0, trace_empty}, 32'd1);
    bus_cycle(16'hFFFC, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 12, cs_n, we_n, first, wd, ca, am);
    check("tr_read_entry", {7'd0, trace_data}, {7'd0, 1'b1, 16'hFFFC, 8'h5A});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
